// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module  : mem_arbiter_pkg
// Purpose : Shared constants for the two-port memory arbiter: FSM state codes
//           and the width of the memory wait counter.
// Config  : ARB_RR_EN (consumed by arb_pick2 / mem_arbiter, not here)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  // FSM state codes, kept at their legacy 2-bit values.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Wait counter width; covers MEM_LAT in 0..15.
  localparam int CNT_W = 4;

  // Index (0/1) of the port selected by a one-hot 2-bit grant.
  function automatic logic grant_idx(input logic [1:0] g);
    return g[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_pick2.sv
// ============================================================================
// Module  : arb_pick2
// Purpose : Two-requester winner selection producing a one-hot grant.
//           ARB_RR_EN defined  : simultaneous requests go to the port that was
//                                not granted last; a lone requester wins.
//           ARB_RR_EN undefined: fixed priority, port 0 over port 1; the
//                                last_grant input does not exist.
// Ports   : req0, req1   - request lines
//           last_grant   - index of the previously granted port (RR only)
//           grant[1:0]   - one-hot winner, 2'b00 when nobody requests
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick2 (
  input  logic       req0,
  input  logic       req1,
`ifdef ARB_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
`ifdef ARB_RR_EN
    if (req0 && req1) begin
      // Contention: hand the access to whoever did not have it last time.
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
`else
    if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Purpose : Arbitrates two requesters (0 = CPU, 1 = DMA/debug) onto a single
//           memory port with a fixed number of wait cycles per access.
//           FSM: IDLE -> BUSY (MEM_LAT+1 cycles) -> DONE (ack pulse) -> IDLE.
// Config  : `define ARB_RR_EN for round-robin on contention (adds the
//           last_grant register); default build is fixed priority, port 0.
// Params  : MEM_LAT (0..15) wait cycles, AW address width, DW data width
// Ports   : clk, reset (async, active-high)
//           req0/we0/addr0/wdata0 -> ack0   requester 0
//           req1/we1/addr1/wdata1 -> ack1   requester 1
//           rdata  - read data of the last completed read
//           gnt    - one-hot owner during BUSY/DONE, zero in IDLE
//           mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  import mem_arbiter_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       gnt_q,   gnt_d;
  logic             we_q,    we_d;
  logic [AW-1:0]    addr_q,  addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [1:0]       pick;

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
`ifdef ARB_RR_EN
  logic last_grant_q, last_grant_d;

  arb_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant      (pick)
  );
`else
  arb_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .grant (pick)
  );
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          // Payload is captured only here; later changes by the requester
          // have no effect on the access in flight.
          gnt_d   = pick;
          cnt_d   = CNT_W'(MEM_LAT);
          state_d = ST_BUSY;
          if (pick[1]) begin
            we_d    = we1;
            addr_d  = addr1;
            wdata_d = wdata1;
          end else begin
            we_d    = we0;
            addr_d  = addr0;
            wdata_d = wdata0;
          end
`ifdef ARB_RR_EN
          last_grant_d = grant_idx(pick);
`endif
        end
      end

      ST_BUSY: begin
        // Counter starts at MEM_LAT, so BUSY spans MEM_LAT+1 cycles and the
        // read data is sampled on the last of them.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef ARB_RR_EN
  // Reset value 1 makes port 0 the winner of the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state so reset clears them at once.
  // --------------------------------------------------------------------------
  assign mem_en    = (state_q == ST_BUSY);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign gnt       = gnt_q;
  assign ack0      = (state_q == ST_DONE) & gnt_q[0];
  assign ack1      = (state_q == ST_DONE) & gnt_q[1];

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Self-checking bench for mem_arbiter. A MEM_LAT=2 instance is
//           exercised with directed and randomized request patterns against a
//           slot-based reference model; a MEM_LAT=0 instance checks the
//           minimum-latency path. Arbitration expectations follow ARB_RR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

  localparam int L    = 2;
  localparam int SLOT = L + 3;   // cycles per access: IDLE + BUSY(L+1) + DONE

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (MEM_LAT = 2)
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, mem_en, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  gnt;

  // Zero-latency DUT
  logic        z_req0, z_we0, z_req1, z_we1;
  logic [31:0] z_addr0, z_wdata0, z_addr1, z_wdata1;
  logic        z_ack0, z_ack1, z_mem_en, z_mem_we;
  logic [31:0] z_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;
  logic [1:0]  z_gnt;

  mem_arbiter #(.MEM_LAT(L), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .gnt(gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(0), .AW(32), .DW(32)) dut_z (
    .clk(clk), .reset(reset),
    .req0(z_req0), .we0(z_we0), .addr0(z_addr0), .wdata0(z_wdata0), .ack0(z_ack0),
    .req1(z_req1), .we1(z_we1), .addr1(z_addr1), .wdata1(z_wdata1), .ack1(z_ack1),
    .rdata(z_rdata), .gnt(z_gnt),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Memory behind the main DUT: 256 words keyed by the low address byte.
  // --------------------------------------------------------------------------
  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  logic [31:0] mem_q   [256];
  bit          written [256];

  assign mem_rdata = written[mem_addr[7:0]] ? mem_q[mem_addr[7:0]]
                                            : init_word(int'(mem_addr[7:0]));

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_q[mem_addr[7:0]]   <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Reference model state
  // --------------------------------------------------------------------------
  logic [31:0] ref_mem [256];
  logic [31:0] rd_exp;
  int          last_m;   // port granted last (starts as 1 after reset)
  int          total = 0;
  int          bad   = 0;

  function automatic logic [1:0] oh(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic int pick_model(input bit c0, input bit c1, input int last);
`ifdef ARB_RR_EN
    if (c0 && c1) return (last == 0) ? 1 : 0;
`endif
    return c0 ? 0 : 1;
  endfunction

  task automatic new_payload(input int p);
    logic [31:0] a;
    a      = $urandom;
    a[7:0] = 8'($urandom_range(0, 15));
    if (p == 0) begin
      we0 = 1'($urandom_range(0, 1)); addr0 = a; wdata0 = $urandom;
    end else begin
      we1 = 1'($urandom_range(0, 1)); addr1 = a; wdata1 = $urandom;
    end
  endtask

  // --------------------------------------------------------------------------
  // Slot-based scenario: ports request p0/p1 accesses, holding req until each
  // ack. Access k occupies cycles k*SLOT .. k*SLOT+L+2 counted from the call.
  // Entered and left on a negedge with the DUT idle.
  // --------------------------------------------------------------------------
  task automatic run_batch(input string name, input int p0, input int p1,
                           input int nslots, input bit scramble, input bit drop);
    int          pend0, pend1, owner, k, ph;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    bit          dropped;
    pend0 = p0; pend1 = p1; owner = 0; dropped = 0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    for (int n = 0; n <= nslots * SLOT; n++) begin
      if (n > 0) @(negedge clk);
      k  = n / SLOT;
      ph = n % SLOT;
      if (ph == 0) begin
        total++;
        if ({mem_en, mem_we, gnt, ack0, ack1} !== 6'b0) begin
          bad++;
          $display("FAIL %s idle_ctrl n=%0d got=%b exp=%b", name, n,
                   {mem_en, mem_we, gnt, ack0, ack1}, 6'b0);
        end
        total++;
        if (rdata !== rd_exp) begin
          bad++;
          $display("FAIL %s idle_rdata n=%0d got=%h exp=%h", name, n, rdata, rd_exp);
        end
        if (k < nslots) begin
          owner  = pick_model(pend0 > 0, pend1 > 0, last_m);
          last_m = owner;
          if (owner == 0) begin
            exp_we = we0; exp_addr = addr0; exp_wdata = wdata0;
          end else begin
            exp_we = we1; exp_addr = addr1; exp_wdata = wdata1;
          end
        end
      end else if (ph <= L + 1) begin
        total++;
        if ({mem_en, mem_we, gnt, ack0, ack1} !== {1'b1, exp_we, oh(owner), 2'b00}) begin
          bad++;
          $display("FAIL %s busy_ctrl n=%0d got=%b exp=%b", name, n,
                   {mem_en, mem_we, gnt, ack0, ack1}, {1'b1, exp_we, oh(owner), 2'b00});
        end
        total++;
        if ({mem_addr, mem_wdata} !== {exp_addr, exp_wdata}) begin
          bad++;
          $display("FAIL %s busy_data n=%0d got=%h/%h exp=%h/%h", name, n,
                   mem_addr, mem_wdata, exp_addr, exp_wdata);
        end
        if (scramble) new_payload(owner);
        if (drop && ph == 1) dropped = 1;
      end else begin
        total++;
        if ({mem_en, mem_we, gnt, ack0, ack1} !==
            {2'b00, oh(owner), owner == 0, owner == 1}) begin
          bad++;
          $display("FAIL %s done_ctrl n=%0d got=%b exp=%b", name, n,
                   {mem_en, mem_we, gnt, ack0, ack1},
                   {2'b00, oh(owner), owner == 0, owner == 1});
        end
        if (exp_we) ref_mem[exp_addr[7:0]] = exp_wdata;
        else        rd_exp = ref_mem[exp_addr[7:0]];
        total++;
        if (rdata !== rd_exp) begin
          bad++;
          $display("FAIL %s done_rdata n=%0d got=%h exp=%h", name, n, rdata, rd_exp);
        end
        if (owner == 0) begin
          pend0--; if (pend0 > 0) new_payload(0);
        end else begin
          pend1--; if (pend1 > 0) new_payload(1);
        end
        if (k == nslots - 1) begin
          pend0 = 0; pend1 = 0;
        end
        dropped = 0;
      end
      req0 = (pend0 > 0) && !(dropped && owner == 0);
      req1 = (pend1 > 0) && !(dropped && owner == 1);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({ack0, ack1, mem_en, mem_we, gnt, mem_addr, mem_wdata, rdata} !== '0) begin
      bad++;
      $display("FAIL reset_main got=%b/%b/%b/%b/%b/%h/%h/%h exp=all zero", ack0, ack1,
               mem_en, mem_we, gnt, mem_addr, mem_wdata, rdata);
    end
    total++;
    if ({z_ack0, z_ack1, z_mem_en, z_mem_we, z_gnt, z_mem_addr, z_mem_wdata, z_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_zlat got=%b/%b/%b/%b/%b/%h/%h/%h exp=all zero", z_ack0, z_ack1,
               z_mem_en, z_mem_we, z_gnt, z_mem_addr, z_mem_wdata, z_rdata);
    end
    reset  = 1'b0;
    last_m = 1;
    rd_exp = '0;
    @(negedge clk);
    total++;
    if ({ack0, ack1, mem_en, gnt, rdata} !== '0) begin
      bad++;
      $display("FAIL reset_release got=%b/%b/%b/%b/%h exp=all zero",
               ack0, ack1, mem_en, gnt, rdata);
    end
  endtask

  task automatic test_read0();
    we0 = 1'b0; addr0 = 32'h0000_0010; wdata0 = $urandom;
    run_batch("read0", 1, 0, 1, 1'b0, 1'b0);
    total++;
    if (rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL read0_value got=%h exp=%h", rdata, 32'hDEADBEEF);
    end
  endtask

  task automatic test_write1();
    we1 = 1'b1; addr1 = 32'h0000_0020; wdata1 = 32'h0000_00A5;
    run_batch("write1", 0, 1, 1, 1'b0, 1'b0);
    total++;
    if (rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL write1_rdata_kept got=%h exp=%h", rdata, 32'hDEADBEEF);
    end
    // Read back the written word through port 0.
    we0 = 1'b0; addr0 = 32'h0000_0020; wdata0 = $urandom;
    run_batch("readback", 1, 0, 1, 1'b0, 1'b0);
    total++;
    if (rdata !== 32'h0000_00A5) begin
      bad++;
      $display("FAIL readback_value got=%h exp=%h", rdata, 32'h0000_00A5);
    end
  endtask

  task automatic test_drop();
    we0 = 1'b0; addr0 = 32'h0000_0005; wdata0 = $urandom;
    run_batch("drop0", 1, 0, 1, 1'b0, 1'b1);
    new_payload(1);
    run_batch("drop1_scramble", 0, 1, 1, 1'b1, 1'b1);
  endtask

  task automatic test_zero_latency();
    z_we0 = 1'b0; z_addr0 = 32'h0000_0040; z_wdata0 = '0; z_req0 = 1'b1;
    @(negedge clk);
    total++;
    if ({z_mem_en, z_ack0, z_ack1, z_gnt} !== 5'b1_0_0_01) begin
      bad++;
      $display("FAIL zlat_busy got=%b exp=%b", {z_mem_en, z_ack0, z_ack1, z_gnt}, 5'b1_0_0_01);
    end
    @(negedge clk);
    total++;
    if ({z_mem_en, z_ack0, z_ack1, z_gnt} !== 5'b0_1_0_01) begin
      bad++;
      $display("FAIL zlat_done got=%b exp=%b", {z_mem_en, z_ack0, z_ack1, z_gnt}, 5'b0_1_0_01);
    end
    total++;
    if (z_rdata !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL zlat_rdata got=%h exp=%h", z_rdata, 32'hCAFEF00D);
    end
    z_req0 = 1'b0;
    @(negedge clk);
    total++;
    if ({z_mem_en, z_ack0, z_ack1, z_gnt} !== 5'b0) begin
      bad++;
      $display("FAIL zlat_idle got=%b exp=%b", {z_mem_en, z_ack0, z_ack1, z_gnt}, 5'b0);
    end
  endtask

  task automatic test_held();
    new_payload(0);
    new_payload(1);
    // Both lines stay high for four accesses; the model decides each winner.
    run_batch("held", 100, 100, 4, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    we0 = 1'b0; addr0 = 32'h0000_0003; wdata0 = $urandom; req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1) begin
      bad++;
      $display("FAIL abort_in_busy got=%b exp=%b", mem_en, 1'b1);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({mem_en, mem_we, ack0, ack1, gnt, mem_addr, mem_wdata, rdata} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got=%b/%b/%b/%b/%b/%h/%h/%h exp=all zero", mem_en,
               mem_we, ack0, ack1, gnt, mem_addr, mem_wdata, rdata);
    end
    req0   = 1'b0;
    last_m = 1;
    rd_exp = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < SLOT + 1; i++) begin
      @(negedge clk);
      total++;
      if ({mem_en, ack0, ack1, gnt} !== 5'b0) begin
        bad++;
        $display("FAIL abort_no_ack i=%0d got=%b exp=%b", i, {mem_en, ack0, ack1, gnt}, 5'b0);
      end
    end
    new_payload(0);
    we0 = 1'b0;
    run_batch("after_reset", 1, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int p0, p1;
    for (int it = 0; it < 25; it++) begin
      p0 = int'($urandom_range(0, 2));
      p1 = int'($urandom_range(0, 2));
      if (p0 + p1 == 0) p0 = 1;
      new_payload(0);
      new_payload(1);
      run_batch("rand", p0, p1, p0 + p1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    z_req0 = 1'b0; z_we0 = 1'b0; z_addr0 = '0; z_wdata0 = '0;
    z_req1 = 1'b0; z_we1 = 1'b0; z_addr1 = '0; z_wdata1 = '0;
    z_mem_rdata = 32'hCAFEF00D;
    last_m = 1;
    rd_exp = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    test_reset();
    test_read0();
    test_write1();
    test_drop();
    test_zero_latency();
    test_held();
    test_reset_abort();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
